// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and control-word bit positions.
// The receiver side imports the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_CLEAR
    } uart_tx_state_t;

    localparam int CTRL_SEND_BIT   = 0;
    localparam int CTRL_RX_NEW_BIT = 1;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/module_uart_tx_ctrl_baud_tick.sv
// Baud-rate tick generator: one-cycle pulse every BAUD_DIV cycles counted from the last clear.
module module_baud_tick #(
    parameter int BAUD_DIV = 1042
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [15:0] TERM_COUNT = 16'(BAUD_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == TERM_COUNT);
        cnt_d  = cnt_q + 16'd1;
        if (clear_i || tick_o) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/module_uart_tx_ctrl.sv
// UART transmit controller: sends one 8N1 frame per SEND request, then writes the
// control word back with SEND cleared so software sees the transfer finish.
module module_uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 1042
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instrucciones_fsm_i,
    input  logic [31:0] data_tx_i,
    output logic        we_fsm_o,
    output logic [31:0] instruccion_fsm_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           tx_q, tx_d;
    logic           we_q, we_d;
    logic [31:0]    instr_q, instr_d;
    logic           baud_clear;
    logic           baud_tick;

    // Counter is held at zero while idle so the start bit gets a full period.
    assign baud_clear = (state_q == ST_IDLE);

    module_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (baud_clear),
        .tick_o  (baud_tick)
    );

    // Outputs are computed from the next state so tx_o, we_fsm_o and the
    // write-back word line up with the state they belong to.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        we_d      = 1'b0;
        instr_d   = 32'd0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (instrucciones_fsm_i[CTRL_SEND_BIT]) begin
                    shift_d   = data_tx_i[7:0];
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    state_d                  = ST_CLEAR;
                    tx_d                     = 1'b1;
                    we_d                     = 1'b1;
                    instr_d                  = instrucciones_fsm_i;
                    instr_d[CTRL_SEND_BIT]   = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            we_q      <= 1'b0;
            instr_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            we_q      <= we_d;
            instr_q   <= instr_d;
        end
    end

    assign tx_o              = tx_q;
    assign we_fsm_o          = we_q;
    assign instruccion_fsm_o = instr_q;
    assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_module_uart_tx_ctrl.sv
// Self-checking bench for module_uart_tx_ctrl at BAUD_DIV=4 against a cycle-indexed frame model.
module tb_module_uart_tx_ctrl;

    localparam int BD    = 4;
    localparam int FRAME = 10 * BD;
    localparam int SPAN  = FRAME + 2;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst    = 1'b0;
    logic [31:0] ctrl   = 32'd0;
    logic [31:0] data   = 32'd0;
    logic        we_o;
    logic [31:0] instr_o;
    logic        tx_o;
    logic        busy_o;

    int checks    = 0;
    int failures  = 0;
    int we_count  = 0;

    logic [34:0] obs [1:2*SPAN];

    module_uart_tx_ctrl #(.BAUD_DIV(BD)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .instrucciones_fsm_i (ctrl),
        .data_tx_i           (data),
        .we_fsm_o            (we_o),
        .instruccion_fsm_o   (instr_o),
        .tx_o                (tx_o),
        .busy_o              (busy_o)
    );

    initial forever #5 if (clk_en) clk = ~clk;

    always @(posedge clk) if (we_o === 1'b1) we_count++;

    // Expected {tx, busy, we, instr} in cycle k, where cycle 1 follows the edge that saw SEND.
    function automatic logic [34:0] exp_vec(input logic [7:0] b, input logic [31:0] wb, input int k);
        int   slot;
        logic t;
        logic busy;
        logic we;
        slot = (k - 1) / BD;
        if (k < 1 || k > FRAME) t = 1'b1;
        else if (slot == 0)     t = 1'b0;
        else if (slot == 9)     t = 1'b1;
        else                    t = b[slot-1];
        busy = (k >= 1 && k <= FRAME + 1);
        we   = (k == FRAME + 1);
        return {t, busy, we, (we ? wb : 32'd0)};
    endfunction

    // Samples n cycles; models the control register (write-back lands on the edge
    // ending CLEAR), an optional mid-frame data change and an optional SEND re-arm.
    task automatic capture(input int n, input int chg_k, input logic [31:0] chg_data,
                           input int resend_k, input logic [31:0] resend_data);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            obs[k] = {tx_o, busy_o, we_o, instr_o};
            if (we_o === 1'b1) ctrl = instr_o;
            if (k == chg_k) data = chg_data;
            if (k == resend_k) begin
                data    = resend_data;
                ctrl[0] = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        checks++;
        if (tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx_o); end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        checks++;
        if (we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", we_o); end
        checks++;
        if (instr_o !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h want=0", instr_o); end
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: checked idle outputs with clock stopped");
    endtask

    task automatic test_basic_frame;
        logic [34:0] e;
        we_count = 0;
        data = 32'h55; ctrl = 32'h1;
        capture(SPAN, 0, 0, 0, 0);
        for (int k = 1; k <= SPAN; k++) begin
            e = exp_vec(8'h55, 32'h0, k);
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL basic cycle=%0d got tx=%b busy=%b we=%b instr=%h want tx=%b busy=%b we=%b instr=%h",
                         k, obs[k][34], obs[k][33], obs[k][32], obs[k][31:0], e[34], e[33], e[32], e[31:0]);
            end
        end
        checks++;
        if (we_count !== 1) begin failures++; $display("FAIL basic_we_pulses got=%0d want=1", we_count); end
        $display("basic: data=0x55 ctrl=0x1 frame sampled over %0d cycles", SPAN);
    endtask

    task automatic test_rx_flag;
        logic [34:0] e;
        data = 32'hA3; ctrl = 32'h3;
        capture(SPAN, 0, 0, 0, 0);
        for (int k = 1; k <= SPAN; k++) begin
            e = exp_vec(8'hA3, 32'h2, k);
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL rx_flag cycle=%0d got tx=%b busy=%b we=%b instr=%h want tx=%b busy=%b we=%b instr=%h",
                         k, obs[k][34], obs[k][33], obs[k][32], obs[k][31:0], e[34], e[33], e[32], e[31:0]);
            end
        end
        $display("rx_flag: data=0xA3 ctrl=0x3 write-back expected 0x2");
    endtask

    task automatic test_mid_change;
        logic [34:0] e;
        we_count = 0;
        data = 32'h0F; ctrl = 32'h1;
        capture(SPAN, 10, 32'hFF, 0, 0);
        for (int k = 1; k <= SPAN; k++) begin
            e = exp_vec(8'h0F, 32'h0, k);
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL mid_change cycle=%0d got tx=%b busy=%b we=%b instr=%h want tx=%b busy=%b we=%b instr=%h",
                         k, obs[k][34], obs[k][33], obs[k][32], obs[k][31:0], e[34], e[33], e[32], e[31:0]);
            end
        end
        checks++;
        if (we_count !== 1) begin failures++; $display("FAIL mid_change_we_pulses got=%0d want=1", we_count); end
        $display("mid_change: data 0x0F changed to 0xFF at cycle 10");
    endtask

    task automatic test_random;
        logic [34:0] e;
        logic [7:0]  b;
        logic [31:0] c;
        int          chg;
        for (int n = 0; n < 4; n++) begin
            b   = 8'($urandom);
            c   = $urandom | 32'h1;
            chg = $urandom_range(1, FRAME);
            data = {24'($urandom), b}; ctrl = c;
            capture(SPAN, chg, $urandom, 0, 0);
            for (int k = 1; k <= SPAN; k++) begin
                e = exp_vec(b, c & ~32'h1, k);
                checks++;
                if (obs[k] !== e) begin
                    failures++;
                    $display("FAIL random%0d cycle=%0d got tx=%b busy=%b we=%b instr=%h want tx=%b busy=%b we=%b instr=%h",
                             n, k, obs[k][34], obs[k][33], obs[k][32], obs[k][31:0], e[34], e[33], e[32], e[31:0]);
                end
            end
            $display("random%0d: data=0x%h ctrl=0x%h data change at cycle %0d", n, b, c, chg);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'($urandom) & 8'hFB;
        we_count = 0;
        data = {24'd0, b}; ctrl = 32'h1;
        capture(14, 0, 0, 0, 0);
        checks++;
        if (obs[14][34] !== 1'b0) begin failures++; $display("FAIL rst_mid_pre_tx got=%b want=0", obs[14][34]); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_o !== 1'b1) begin failures++; $display("FAIL rst_mid_tx got=%b want=1", tx_o); end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b want=0", busy_o); end
        @(negedge clk);
        ctrl = 32'h0;
        rst  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
                failures++;
                $display("FAIL rst_mid_idle cycle=%0d got busy=%b tx=%b want busy=0 tx=1", k, busy_o, tx_o);
            end
        end
        checks++;
        if (we_count !== 0) begin failures++; $display("FAIL rst_mid_we_pulses got=%0d want=0", we_count); end
        $display("reset_mid_frame: data=0x%h reset in third data bit", b);
    endtask

    task automatic test_back_to_back;
        logic [34:0] e;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [31:0] c;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        c  = $urandom | 32'h1;
        we_count = 0;
        data = {24'd0, b1}; ctrl = c;
        capture(2 * SPAN, 0, 0, SPAN, {24'd0, b2});
        for (int k = 1; k <= 2 * SPAN; k++) begin
            e = (k <= SPAN) ? exp_vec(b1, c & ~32'h1, k) : exp_vec(b2, c & ~32'h1, k - SPAN);
            checks++;
            if (obs[k] !== e) begin
                failures++;
                $display("FAIL b2b cycle=%0d got tx=%b busy=%b we=%b instr=%h want tx=%b busy=%b we=%b instr=%h",
                         k, obs[k][34], obs[k][33], obs[k][32], obs[k][31:0], e[34], e[33], e[32], e[31:0]);
            end
        end
        checks++;
        if (we_count !== 2) begin failures++; $display("FAIL b2b_we_pulses got=%0d want=2", we_count); end
        $display("back_to_back: data=0x%h then 0x%h ctrl=0x%h", b1, b2, c);
    endtask

    initial begin
        #1;
        test_reset;
        test_basic_frame;
        test_rx_flag;
        test_mid_change;
        test_random;
        test_reset_mid_frame;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/module_uart_tx_ctrl.md
# module_uart_tx_ctrl

Transmit side of the UART peripheral: consumes the control word held in the UART control register, serializes one byte from the data register as an 8N1 frame on `tx_o`, then writes the control word back through the register's FSM write port with the send bit cleared. Sits between the control/data registers, which the micro writes, and the board TX pin. The send bit is the software-visible busy flag: software polls it until it reads 0.

## Interface
Parameters:
- `BAUD_DIV`, default 1042, clock cycles per bit (10 MHz / 9600); legal range 2..65535.

Ports:
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `instrucciones_fsm_i`  in  32  current control register contents
- `data_tx_i`  in  32  data register; bits [7:0] are the byte to send
- `we_fsm_o`  out  1  write strobe to the control register's FSM port
- `instruccion_fsm_o`  out  32  write-back control word
- `tx_o`  out  1  serial line, idle high
- `busy_o`  out  1  high whenever state is not IDLE

## Operation
- Control bit map:
  - bit 0 = SEND, the transmit request.
  - bit 1 = RX_NEW, owned by the receiver; never modified here.
  - bits 31:2 are passed through unchanged.
- FSM states: IDLE, START, DATA, STOP, CLEAR.
- **IDLE:** `tx_o`=1. If SEND=1:
  - latch `data_tx_i[7:0]` into the shift register;
  - clear the baud counter and bit index;
  - go to START.
- **START:** `tx_o`=0 for BAUD_DIV cycles, then go to DATA.
- **DATA:** 8 bits, LSB first, each held BAUD_DIV cycles. The bit index runs 0..7; after index 7 expires, go to STOP.
- **STOP:** `tx_o`=1 for BAUD_DIV cycles, then go to CLEAR.
- **CLEAR:** one cycle, then IDLE.
  - `we_fsm_o`=1.
  - `instruccion_fsm_o` = `instrucciones_fsm_i` with bit 0 forced to 0.
- Outside CLEAR: `we_fsm_o`=0 and `instruccion_fsm_o`=0.
- SEND is sampled only in IDLE. Changes to SEND or `data_tx_i` during START..STOP have no effect on the frame in flight.
- The FSM port has priority at the control register, so a micro write landing in the CLEAR cycle is lost. Software must not write the control register while SEND reads 1.
- Baud counter: 16 bits, counts 0..BAUD_DIV-1. A terminal-count tick advances the bit and state; the counter wraps to 0 on the tick.

## Timing
- Reset values:
  - state IDLE;
  - `tx_o`=1, `busy_o`=0;
  - `we_fsm_o`=0, `instruccion_fsm_o`=0;
  - shift register, counter and bit index all 0.
- `rst_i` is asynchronous: asserting it mid-frame forces `tx_o`=1 and `busy_o`=0 without waiting for a clock edge. No write-back occurs.
- `tx_o` is registered. It falls on the first edge after the edge at which IDLE sees SEND=1. That edge is cycle 0.
- Frame length is 10×BAUD_DIV cycles: start bit on cycles 1..BAUD_DIV, then data bits, then stop bit.
- `we_fsm_o` is high during cycle 10×BAUD_DIV+1 (the CLEAR state).
- The control register updates on the edge ending CLEAR, so IDLE sees the cleared SEND on the next cycle. No double send.
- `busy_o` is a Moore output: high from cycle 1 through the CLEAR cycle inclusive.
- Back-to-back frames: if software re-sets SEND immediately, the minimum gap between stop bit end and the next start bit is 2 cycles (CLEAR + IDLE).

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t`;
  - constants `CTRL_SEND_BIT`=0, `CTRL_RX_NEW_BIT`=1, `UART_DATA_BITS`=8.
- The receiver side uses the same package.
- Sub-module `module_baud_tick`:
  - parameter BAUD_DIV; inputs `clk_i`, `rst_i`, `clear_i`; output `tick_o`;
  - `tick_o` is a one-cycle pulse every BAUD_DIV cycles after `clear_i`.
- FSM, shift register and write-back mux stay in the top module.

## Test plan
All scenarios run with BAUD_DIV=4.
- **Reset:** assert `rst_i` with no clock running → `tx_o`=1, `busy_o`=0, `we_fsm_o`=0, `instruccion_fsm_o`=0.
- **Basic frame:** `data_tx_i`=0x55, ctrl=0x1 → `tx_o` is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `we_fsm_o` pulses one cycle at cycle 41 with `instruccion_fsm_o`=0x0.
- **RX flag preserved:** ctrl=0x3, `data_tx_i`=0xA3 → data bits 1,1,0,0,0,1,0,1; write-back value 0x2.
- **Mid-frame data change:** `data_tx_i`=0x0F at cycle 0, changed to 0xFF at cycle 10 → frame still carries 0x0F; exactly one `we_fsm_o` pulse.
- **Reset mid-frame:** `rst_i` asserted during the 3rd data bit → `tx_o`=1 in the same cycle and no `we_fsm_o`. After release with ctrl=0, the block remains IDLE.
- **Back-to-back:** bench model re-sets SEND the cycle after write-back → second start bit begins exactly 2 cycles after the first stop bit ends; two write-back pulses in total.
